ttl_out_stage: RTL and testbench

Output stage placed directly downstream of the RTOB core. Each `counter_matched` strobe carries a data byte in `rto_out`, which this block applies to the physical TTL lines. A channel either takes the byte bit as a new level (level mode) or fires a fixed-width pulse when the bit is 1 (pulse mode). The block also keeps per-channel rising-edge counters, a last-event timestamp and a sticky retrigger flag for host readback.

---
 rtl/ttl_out_stage.sv | 173 +++++++++++++++++
 tb/tb_ttl_out_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_out_stage.sv
// ttl_out_stage: drives TTL pins from RTOB event bytes in level or
// fixed-width pulse mode, with edge counters and timestamp readback.
module ttl_out_stage #(
  parameter int CH_NUM  = 8,
  parameter int PW_LEN  = 16,
  parameter int CNT_LEN = 32,
  localparam int SW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               counter_matched,
  input  logic [127:0]       rto_out,
  input  logic [CH_NUM-1:0]  pulse_mode,
  input  logic [PW_LEN-1:0]  pulse_width,
  input  logic [CH_NUM-1:0]  polarity,
  input  logic               clear_counters,
  input  logic [SW-1:0]      cnt_sel,
  output logic [CH_NUM-1:0]  ttl_out,
  output logic [CNT_LEN-1:0] edge_count,
  output logic [63:0]        last_timestamp,
  output logic               retrigger_error,
  output logic               busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } ch_state_t;

  ch_state_t          state_q [CH_NUM];
  ch_state_t          state_d [CH_NUM];
  logic [PW_LEN-1:0]  timer_q [CH_NUM];
  logic [PW_LEN-1:0]  timer_d [CH_NUM];
  logic [CNT_LEN-1:0] cnt_q   [CH_NUM];

  logic [CH_NUM-1:0]  level_q;
  logic [CH_NUM-1:0]  level_d;
  logic [CH_NUM-1:0]  level_d1;
  logic [CH_NUM-1:0]  lvl_ev;
  logic [CH_NUM-1:0]  fire;
  logic [CH_NUM-1:0]  retrig;
  logic [CH_NUM-1:0]  rise;
  logic [PW_LEN-1:0]  load_val;
  logic               clr_d1;
  logic [63:0]        ts_q;
  logic [CNT_LEN-1:0] sel_q;
  logic               rte_q;
  logic               unused_bits;

  assign unused_bits = ^rto_out[63:CH_NUM];

  assign load_val = (pulse_width == '0) ? '0
                  : pulse_width - PW_LEN'(1);

  assign lvl_ev = {CH_NUM{counter_matched}} & ~pulse_mode;
  assign fire   = {CH_NUM{counter_matched}} & pulse_mode
                & rto_out[CH_NUM-1:0];
  assign rise   = level_q & ~level_d1;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      level_d[i] = level_q[i];
      retrig[i]  = 1'b0;
      unique case (1'b1)
        lvl_ev[i]: begin
          level_d[i] = rto_out[i];
          timer_d[i] = '0;
          state_d[i] = IDLE;
        end
        fire[i]: begin
          level_d[i] = 1'b1;
          timer_d[i] = load_val;
          state_d[i] = PULSE;
          retrig[i]  = (state_q[i] == PULSE);
        end
        default: begin
          if (state_q[i] == PULSE) begin
            if (timer_q[i] == '0) begin
              level_d[i] = 1'b0;
              state_d[i] = IDLE;
            end else begin
              timer_d[i] = timer_q[i] - PW_LEN'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
      level_q  <= '0;
      level_d1 <= '0;
    end else if (flush) begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
      level_q  <= '0;
      level_d1 <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      level_q  <= level_d;
      level_d1 <= level_q;
    end
  end

  // a clear also swallows the rise created by an event in its own cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= '0;
      end
      clr_d1 <= 1'b0;
    end else begin
      clr_d1 <= clear_counters & ~flush;
      for (int i = 0; i < CH_NUM; i++) begin
        if (flush || clear_counters) begin
          cnt_q[i] <= '0;
        end else if (rise[i] && !clr_d1 && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + CNT_LEN'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q  <= '0;
      rte_q <= 1'b0;
      sel_q <= '0;
    end else if (flush) begin
      ts_q  <= '0;
      rte_q <= 1'b0;
      sel_q <= '0;
    end else begin
      if (counter_matched) begin
        ts_q <= rto_out[127:64];
      end
      if (clear_counters) begin
        rte_q <= 1'b0;
      end else if (|retrig) begin
        rte_q <= 1'b1;
      end
      sel_q <= cnt_q[cnt_sel];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (state_q[i] == PULSE) begin
        busy = 1'b1;
      end
    end
  end

  assign ttl_out         = level_q ^ polarity;
  assign edge_count      = sel_q;
  assign last_timestamp  = ts_q;
  assign retrigger_error = rte_q;

endmodule

// File: tb/tb_ttl_out_stage.sv
// tb_ttl_out_stage: vector table plus cycle-tagged scoreboard
// for the TTL output stage.
`timescale 1ns/1ps
module tb_ttl_out_stage;

  localparam int K_TTL    = 0;
  localparam int K_BUSY   = 1;
  localparam int K_EDGE   = 2;
  localparam int K_TS     = 3;
  localparam int K_RTE    = 4;
  localparam int K_EDGE_S = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
    logic [63:0] mask;
    string       nm;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] pol;
    logic [7:0] exp_ttl;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         counter_matched;
  logic         clear_counters;
  logic [127:0] rto_out;
  logic [7:0]   pulse_mode;
  logic [7:0]   polarity;
  logic [15:0]  pulse_width;
  logic [2:0]   cnt_sel;
  logic [7:0]   ttl_out;
  logic [31:0]  edge_count;
  logic [63:0]  last_timestamp;
  logic         retrigger_error;
  logic         busy;
  logic [7:0]   ttl_unused_s;
  logic [1:0]   edge_count_s;
  logic [63:0]  ts_unused_s;
  logic         rte_unused_s;
  logic         busy_unused_s;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ttl_out_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .counter_matched(counter_matched), .rto_out(rto_out),
    .pulse_mode(pulse_mode), .pulse_width(pulse_width),
    .polarity(polarity), .clear_counters(clear_counters),
    .cnt_sel(cnt_sel), .ttl_out(ttl_out),
    .edge_count(edge_count), .last_timestamp(last_timestamp),
    .retrigger_error(retrigger_error), .busy(busy)
  );

  ttl_out_stage #(.CNT_LEN(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .counter_matched(counter_matched), .rto_out(rto_out),
    .pulse_mode(pulse_mode), .pulse_width(pulse_width),
    .polarity(polarity), .clear_counters(clear_counters),
    .cnt_sel(cnt_sel), .ttl_out(ttl_unused_s),
    .edge_count(edge_count_s), .last_timestamp(ts_unused_s),
    .retrigger_error(rte_unused_s), .busy(busy_unused_s)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [63:0] obs(input int k);
    case (k)
      K_TTL:   obs = 64'(ttl_out);
      K_BUSY:  obs = 64'(busy);
      K_EDGE:  obs = 64'(edge_count);
      K_TS:    obs = last_timestamp;
      K_RTE:   obs = 64'(retrigger_error);
      default: obs = 64'(edge_count_s);
    endcase
  endfunction

  task automatic expect_at(input int c, input int k, input logic [63:0] v,
                           input logic [63:0] m, input string nm);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.mask = m; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic push_pulse(input int ch, input int n, input int w);
    logic [63:0] m;
    m = 64'(1) << ch;
    for (int k = 1; k <= w; k++) begin
      expect_at(n + k, K_TTL, m, m, "pulse_hi");
      expect_at(n + k, K_BUSY, 1, 1, "busy_hi");
    end
    expect_at(n + w + 1, K_TTL, 0, m, "pulse_lo");
    expect_at(n + w + 1, K_BUSY, 0, 1, "busy_lo");
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].nm, obs(sb[i].kind) & sb[i].mask,
              sb[i].val & sb[i].mask);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: slot %0d missed at cyc %0d",
                 sb[i].nm, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire_ev(input logic [7:0] d, input logic [63:0] ts);
    rto_out = {ts, 56'h0, d};
    counter_matched = 1'b1;
    tick();
    counter_matched = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
  endtask

  vec_t        vec[6];
  int          exp_cnt[8];
  logic [7:0]  lv;
  logic [63:0] ts;
  int          n;
  int          m;

  initial begin
    reset_n = 1'b0; flush = 1'b0; counter_matched = 1'b0;
    clear_counters = 1'b0; rto_out = '0; pulse_mode = '0;
    polarity = '0; pulse_width = '0; cnt_sel = '0;
    #2;
    check("rst_ttl", 64'(ttl_out), 0);
    check("rst_edge", 64'(edge_count), 0);
    check("rst_ts", last_timestamp, 0);
    check("rst_rte", 64'(retrigger_error), 0);
    check("rst_busy", 64'(busy), 0);
    polarity = 8'h5A;
    #1;
    check("rst_pol", 64'(ttl_out), 64'h5A);
    polarity = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // level mode table
    vec[0] = '{8'hA5, 8'h00, 8'hA5};
    vec[1] = '{8'h00, 8'h00, 8'h00};
    vec[2] = '{8'hFF, 8'h00, 8'hFF};
    vec[3] = '{8'h3C, 8'h0F, 8'h33};
    vec[4] = '{8'h00, 8'h0F, 8'h0F};
    vec[5] = '{8'hC3, 8'h00, 8'hC3};
    lv = '0;
    for (int c = 0; c < 8; c++) exp_cnt[c] = 0;
    for (int i = 0; i < 6; i++) begin
      polarity = vec[i].pol;
      n = cyc;
      ts = 64'h0123_4567_0000_0000 | 64'(i + 1);
      expect_at(n + 1, K_TTL, 64'(vec[i].exp_ttl), 64'hFF, "lvl_ttl");
      expect_at(n + 1, K_TS, ts, '1, "lvl_ts");
      for (int c = 0; c < 8; c++)
        if (vec[i].data[c] && !lv[c]) exp_cnt[c]++;
      lv = vec[i].data;
      fire_ev(vec[i].data, ts);
      tick();
    end
    polarity = '0;
    repeat (3) tick();
    for (int c = 0; c < 8; c++) begin
      cnt_sel = 3'(c);
      expect_at(cyc + 1, K_EDGE, 64'(exp_cnt[c]), '1, "lvl_cnt");
      tick();
    end
    fire_ev(8'h00, 64'h0);
    pulse_clear();
    cnt_sel = 3'd0;
    tick();
    tick();
    expect_at(cyc, K_EDGE, 0, '1, "clr_cnt");

    // pulse width 5 on ch0
    pulse_mode = 8'h01;
    pulse_width = 16'd5;
    n = cyc;
    expect_at(n, K_TTL, 0, 1, "pw5_pre");
    push_pulse(0, n, 5);
    fire_ev(8'h01, 64'h55);
    repeat (8) tick();
    expect_at(cyc, K_EDGE, 1, '1, "pw5_cnt");
    tick();

    // retrigger, width 4, events two cycles apart
    pulse_clear();
    pulse_width = 16'd4;
    n = cyc;
    expect_at(n + 1, K_TTL, 1, 1, "rt_hi");
    expect_at(n + 2, K_TTL, 1, 1, "rt_hi");
    expect_at(n + 2, K_RTE, 0, 1, "rt_flag_pre");
    expect_at(n + 3, K_RTE, 1, 1, "rt_flag");
    push_pulse(0, n + 2, 4);
    fire_ev(8'h01, 64'h66);
    tick();
    fire_ev(8'h01, 64'h67);
    repeat (6) tick();
    expect_at(cyc, K_EDGE, 1, '1, "rt_cnt");
    expect_at(cyc, K_RTE, 1, 1, "rt_sticky");
    tick();
    n = cyc;
    expect_at(n + 1, K_RTE, 0, 1, "clr_rte");
    pulse_clear();
    tick();

    // clear together with the edge and with a retrigger
    n = cyc;
    expect_at(n + 1, K_TTL, 1, 1, "cv_hi");
    push_pulse(0, n + 1, 4);
    expect_at(n + 2, K_RTE, 0, 1, "clr_vs_retrig");
    expect_at(n + 3, K_RTE, 0, 1, "clr_vs_retrig");
    fire_ev(8'h01, 64'h70);
    clear_counters = 1'b1;
    fire_ev(8'h01, 64'h71);
    clear_counters = 1'b0;
    repeat (7) tick();
    expect_at(cyc, K_EDGE, 0, '1, "clr_vs_edge");
    tick();

    // pulse width 0 acts as 1
    pulse_width = 16'd0;
    n = cyc;
    push_pulse(0, n, 1);
    fire_ev(8'h01, 64'h80);
    repeat (3) tick();

    // inverted polarity in level mode
    pulse_mode = 8'h00;
    polarity = 8'h01;
    expect_at(cyc, K_TTL, 1, 1, "pol_idle");
    expect_at(cyc + 1, K_TTL, 0, 1, "pol_ev1");
    fire_ev(8'h01, 64'h90);
    tick();
    expect_at(cyc + 1, K_TTL, 1, 1, "pol_ev0");
    fire_ev(8'h00, 64'h91);
    tick();
    polarity = 8'h00;

    // saturation on a 2-bit counter build, ch1
    pulse_clear();
    cnt_sel = 3'd1;
    for (int r = 0; r < 4; r++) begin
      fire_ev(8'h02, 64'hA0);
      fire_ev(8'h00, 64'hA1);
      tick();
      tick();
      expect_at(cyc, K_EDGE_S, (r < 3) ? 64'(r + 1) : 64'd3, '1,
                "sat_cnt");
      expect_at(cyc, K_EDGE, 64'(r + 1), '1, "wide_cnt");
    end
    cnt_sel = 3'd0;
    tick();

    // flush mid-pulse with a same-cycle event
    pulse_mode = 8'h01;
    pulse_width = 16'd10;
    n = cyc;
    for (int k = 1; k <= 4; k++)
      expect_at(n + k, K_TTL, 1, 1, "fl_pre_hi");
    expect_at(n + 3, K_RTE, 1, 1, "fl_pre_rte");
    expect_at(n + 3, K_EDGE, 1, '1, "fl_pre_cnt");
    expect_at(n + 2, K_TS, 64'hBEEF, '1, "fl_pre_ts");
    fire_ev(8'h01, 64'hBEEE);
    fire_ev(8'h01, 64'hBEEF);
    tick();
    tick();
    m = cyc;
    expect_at(m + 1, K_TTL, 0, 64'hFF, "fl_ttl");
    expect_at(m + 1, K_BUSY, 0, 1, "fl_busy");
    expect_at(m + 1, K_RTE, 0, 1, "fl_rte");
    expect_at(m + 1, K_TS, 0, '1, "fl_ts");
    expect_at(m + 2, K_EDGE, 0, '1, "fl_cnt");
    expect_at(m + 2, K_TTL, 0, 1, "fl_drop");
    flush = 1'b1;
    fire_ev(8'h01, 64'hCAFE);
    flush = 1'b0;
    repeat (3) tick();

    // async reset mid-pulse
    fire_ev(8'h01, 64'hD00D);
    fire_ev(8'h01, 64'hD00E);
    tick();
    check("pre_rst_ttl", 64'(ttl_out[0]), 1);
    check("pre_rst_rte", 64'(retrigger_error), 1);
    check("pre_rst_cnt", 64'(edge_count), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("ar_ttl", 64'(ttl_out), 0);
    check("ar_busy", 64'(busy), 0);
    check("ar_ts", last_timestamp, 0);
    check("ar_cnt", 64'(edge_count), 0);
    check("ar_rte", 64'(retrigger_error), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    expect_at(cyc, K_TTL, 0, 64'hFF, "post_rst_ttl");
    expect_at(cyc, K_BUSY, 0, 1, "post_rst_busy");
    repeat (3) tick();

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: slot %0d never sampled", sb[0].nm, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
